// File: rtl/bch_gfmul_sched_if.sv
// Bus bundle between the BCH decoder clients, the multiplier scheduler and the shared
// bit-serial GF(2^m) multiplier core.
interface bch_gfmul_sched_if #(
  parameter int C_INWIDTH = 31,
  parameter int C_NREQ    = 4
);
  logic [C_NREQ-1:0]           I_Req_v;
  logic [C_NREQ*C_INWIDTH-1:0] I_Req_a;
  logic [C_NREQ*C_INWIDTH-1:0] I_Req_b;
  logic [C_NREQ-1:0]           O_Req_rdy;
  logic [C_NREQ-1:0]           O_Resp_v;
  logic [C_INWIDTH-1:0]        O_Resp_data;
  logic [C_INWIDTH-1:0]        O_Mul_a;
  logic [C_INWIDTH-1:0]        O_Mul_b;
  logic                        O_Mul_v;
  logic [C_INWIDTH-1:0]        I_Mul_prod;
  logic                        O_Busy;

  // Scheduler side.
  modport slave (
    input  I_Req_v, I_Req_a, I_Req_b, I_Mul_prod,
    output O_Req_rdy, O_Resp_v, O_Resp_data, O_Mul_a, O_Mul_b, O_Mul_v, O_Busy
  );

  // Client and multiplier-core side.
  modport master (
    output I_Req_v, I_Req_a, I_Req_b, I_Mul_prod,
    input  O_Req_rdy, O_Resp_v, O_Resp_data, O_Mul_a, O_Mul_b, O_Mul_v, O_Busy
  );
endinterface

// File: rtl/bch_gfmul_sched.sv
// Round-robin scheduler sharing one bit-serial GF(2^m) multiplier among C_NREQ BCH clients.
// Optional macro BCH_GFMUL_ZERO_BYPASS_EN: zero-operand requests skip the core and answer 0.
module bch_gfmul_sched #(
  parameter int C_INWIDTH = 31,
  parameter int C_NREQ    = 4
) (
  input  logic             I_clk,
  input  logic             I_rst,
  bch_gfmul_sched_if.slave bus
);

  localparam int PW = (C_NREQ > 1) ? $clog2(C_NREQ) : 1;
  localparam int CW = (C_INWIDTH > 1) ? $clog2(C_INWIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(C_INWIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [C_NREQ-1:0]    id_q, id_d;
  logic [C_INWIDTH-1:0] op_a_q, op_a_d;
  logic [C_INWIDTH-1:0] op_b_q, op_b_d;
  logic [C_INWIDTH-1:0] resp_q, resp_d;

  logic [C_INWIDTH-1:0] req_a [C_NREQ];
  logic [C_INWIDTH-1:0] req_b [C_NREQ];

  logic                 grant_found;
  logic [PW-1:0]        grant_idx;
  logic [C_NREQ-1:0]    grant_oh;
  logic                 rdy_en;
  logic                 accept;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= C_NREQ) begin
      sum = sum - C_NREQ;
    end
    return PW'(sum);
  endfunction

  generate
    for (genvar gi = 0; gi < C_NREQ; gi++) begin : g_req
      assign req_a[gi]    = bus.I_Req_a[gi*C_INWIDTH +: C_INWIDTH];
      assign req_b[gi]    = bus.I_Req_b[gi*C_INWIDTH +: C_INWIDTH];
      assign grant_oh[gi] = grant_found && (grant_idx == PW'(gi));
    end
  endgenerate

  // First pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < C_NREQ; k++) begin
      if (!grant_found && bus.I_Req_v[wrap_inc(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_inc(rr_ptr_q, k);
      end
    end
  end

  // No grants while reset is held, so nothing is lost to a discarded accept.
  assign rdy_en = (state_q == S_IDLE) && !I_rst;
  assign accept = rdy_en && grant_found;

`ifdef BCH_GFMUL_ZERO_BYPASS_EN
  logic zero_op;
  assign zero_op = (req_a[grant_idx] == '0) || (req_b[grant_idx] == '0);
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    resp_d   = resp_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_a_d   = req_a[grant_idx];
          op_b_d   = req_b[grant_idx];
          id_d     = grant_oh;
          rr_ptr_d = wrap_inc(grant_idx, 1);
`ifdef BCH_GFMUL_ZERO_BYPASS_EN
          if (zero_op) begin
            resp_d  = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
`else
          state_d  = S_LOAD;
`endif
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          resp_d  = bus.I_Mul_prod;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      id_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      resp_q   <= resp_d;
    end
  end

  // Core operands stay on the latched values for the whole operation.
  assign bus.O_Req_rdy   = rdy_en ? grant_oh : '0;
  assign bus.O_Mul_v     = (state_q == S_LOAD);
  assign bus.O_Mul_a     = op_a_q;
  assign bus.O_Mul_b     = op_b_q;
  assign bus.O_Resp_v    = (state_q == S_DONE) ? id_q : '0;
  assign bus.O_Resp_data = (state_q == S_DONE) ? resp_q : '0;
  assign bus.O_Busy      = (state_q != S_IDLE);

endmodule

// File: doc/bch_gfmul_sched.md
# bch_gfmul_sched

Round-robin scheduler that shares one bit-serial GF(2^m) multiplier core among several BCH decoder clients, such as the syndrome, error-locator and Chien stages. It accepts operand pairs from up to C_NREQ requesters and loads one pair into the multiplier. It waits out the serial computation, then returns the product to the requester that issued it. The block sits between the decoder stages and the single multiplier instance.

## Interface
- C_INWIDTH, 31, field width m; operand, product and multiplier-serial-cycle count.
- C_NREQ, 4, number of requesters (2..8).
- I_clk  in  1  clock.
- I_rst  in  1  synchronous, active-high reset.
- I_Req_v  in  C_NREQ  per-requester request valid.
- I_Req_a  in  C_NREQ*C_INWIDTH  multiplicand, requester i at slice [i*C_INWIDTH +: C_INWIDTH].
- I_Req_b  in  C_NREQ*C_INWIDTH  multiplier, same slicing.
- O_Req_rdy  out  C_NREQ  one-hot grant; a request is accepted on the cycle when I_Req_v[i] & O_Req_rdy[i].
- O_Resp_v  out  C_NREQ  one-cycle pulse, product ready for requester i.
- O_Resp_data  out  C_INWIDTH  product, shared by all requesters, qualified by O_Resp_v.
- O_Mul_a  out  C_INWIDTH  multiplicand to core.
- O_Mul_b  out  C_INWIDTH  multiplier to core.
- O_Mul_v  out  1  load strobe to core.
- I_Mul_prod  in  C_INWIDTH  core product, valid C_INWIDTH cycles after the cycle following the load.
- O_Busy  out  1  high in any state other than IDLE.

## Operation
- FSM has four states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - O_Req_rdy is combinational. It is one-hot on the first asserted I_Req_v found by searching from rr_ptr upward, modulo C_NREQ.
  - If no request is pending, O_Req_rdy is 0.
  - On accept, latch the operands and the one-hot grant id, set rr_ptr to (granted+1) mod C_NREQ, and go to LOAD.
- LOAD:
  - O_Mul_v=1 for exactly one cycle, with O_Mul_a and O_Mul_b driven from the latched operands.
  - Clear cnt to 0 and go to RUN.
- RUN:
  - Increment cnt each cycle.
  - When cnt reaches C_INWIDTH-1, capture I_Mul_prod into the response register and go to DONE.
- DONE:
  - O_Resp_v[id]=1 and O_Resp_data equals the captured product, for exactly one cycle.
  - Go to IDLE.
- O_Mul_a and O_Mul_b hold the latched operands from LOAD through DONE. They are held stable so the core sees constant inputs.
- Responses have no backpressure. The requester must take the data in the DONE cycle.
- Outside IDLE, O_Req_rdy=0. Requesters hold I_Req_v and their operands until granted. Deasserting I_Req_v before grant withdraws the request with no side effects.
- cnt is ceil(log2(C_INWIDTH)) bits wide, with no wrap inside RUN.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, cnt=0.
  - O_Req_rdy: combinational from I_Req_v with rr_ptr=0, so requester 0 has highest priority.
  - O_Resp_v=0, O_Resp_data=0, O_Mul_v=0, O_Mul_a=0, O_Mul_b=0, O_Busy=0.
- A reset mid-operation in any state aborts the operation: return to IDLE with no response pulse and no O_Mul_v.
- Latency, with accept at cycle T:
  - O_Mul_v at T+1.
  - RUN spans T+2 .. T+C_INWIDTH+1.
  - O_Resp_v at T+C_INWIDTH+2.
- The earliest next accept is T+C_INWIDTH+3, giving an issue interval of C_INWIDTH+3 cycles.
- Simultaneous requests resolve by round-robin. Under continuous requests from all clients, each gets one grant per C_NREQ operations.
- A requester whose response pulses in DONE may re-request. It is eligible in the following IDLE cycle subject to rr_ptr.

## Configuration
- BCH_GFMUL_ZERO_BYPASS_EN, when defined:
  - An accepted request with a==0 or b==0 goes IDLE→DONE directly.
  - O_Resp_v fires at T+1 with O_Resp_data=0.
  - O_Mul_v is not asserted, and the next accept is possible at T+2.
  - rr_ptr updates as normal.
- When undefined, zero operands take the full multiply path with the normal latency.

## Test plan
- Single op, C_INWIDTH=31: requester 2 sends a=31'h1, b=31'h2 → O_Req_rdy=4'b0100 at T, O_Mul_v at T+1, O_Resp_v=4'b0100 with data 31'h2 at T+33.
- All four requesters hold I_Req_v=4'hF after reset → grants in order 0,1,2,3,0, spaced 34 cycles apart. Each response pulses only its own O_Resp_v bit.
- Random operands checked against a golden GF(2^31) model with the bit-serial core attached → every O_Resp_data matches and every latency is exactly 33 cycles.
- I_rst asserted at T+10 of an operation → no O_Resp_v, state returns to IDLE, and the next request from requester 3 with 0 pending elsewhere is granted the cycle after reset deasserts.
- Requester 1 drops I_Req_v while requester 0 is busy → no later grant or response to requester 1.
- Zero operand a=0, b=31'h5: with BCH_GFMUL_ZERO_BYPASS_EN, response 0 at T+1 and no O_Mul_v. Without it, response 0 at T+33.
